ssd_scan_decoder: RTL and testbench
===================================

# ssd_scan_decoder

Recovers the ping-pong counter value and direction from the multiplexed seven-segment drive lines (segment bus plus digit-select strobes) produced by the display driver. It is the decode end of the display interface. It filters scan transitions, decodes each digit pattern back to a value, and checks frame order and consistency. It publishes one validated {value, direction} result per complete 4-digit scan. It sits on the FPGA board beside the display path as a self-check and loopback monitor, and drives LEDs or a bench scoreboard.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples of {an_in, seg_in} required to accept a digit; legal range 2..255.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  8  active-low segment bus, bit7=a … bit1=g, bit0=dp.
- an_in  in  4  active-low digit select; 0111=pos3 (tens), 1011=pos2 (units), 1101=pos1 (arrow), 1110=pos0 (arrow).
- value  out  4  last validated counter value, 0..15.
- dir  out  1  last validated direction; 1=up, 0=down.
- frame_valid  out  1  one-cycle pulse when value/dir update.
- err  out  1  one-cycle pulse when a frame is discarded.
- err_code  out  2  cause of the last err; held until the next err. 01=illegal pattern, 10=sequence, 11=range or arrow mismatch.

## Operation
- Input stage: seg_in/an_in registered once; reset values FF/F.
- Stability filter:
  - 8-bit counter compares the registered pair with the previous registered pair.
  - Equal: increment, saturating at 255. Different: load 1.
  - When the counter reaches exactly STABLE_CYCLES, one accept strobe fires. There is no re-accept until the pair changes.
  - A pair whose an is not one-hot-low (1111, or two or more low bits) is blanking. It never accepts and never errors, and it does not disturb frame state.
- Digit decode on accept:
  - pos3: 00000011→tens 0; 10011111→tens 1.
  - pos2: codes for 0..9 are 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001.
  - pos1/pos0: 00111011→up (1); 11000111→down (0).
  - Any other code at that position is illegal (code 01).
- Frame FSM (states WAIT3, HAVE3, HAVE2, HAVE1):
  - WAIT3: accepted pos3 → HAVE3. Accepted pos2/1/0 are silently ignored (resync).
  - HAVE3 expects pos2 → HAVE2. HAVE2 expects pos1 → HAVE1. HAVE1 expects pos0 → completion, then WAIT3.
  - An accepted unexpected position in HAVE3/HAVE2/HAVE1 raises err with code 10. It then goes to HAVE3 if that position was pos3, else WAIT3.
  - An illegal pattern in any state other than WAIT3 raises err with code 01 → WAIT3. An illegal pos3 pattern in WAIT3 raises err with code 01 and stays in WAIT3.
- Completion checks:
  - result = tens*10 + units, computed at 5 bits. result > 15 gives code 11.
  - The pos1 arrow must equal the pos0 arrow, else code 11.
  - On pass: value ← result[3:0], dir ← arrow, frame_valid pulses.
  - On fail: value/dir are unchanged and err pulses.
- frame_valid and err are never high in the same cycle.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - value=0, dir=1, frame_valid=0, err=0, err_code=00.
  - FSM=WAIT3, stability counter=0, input regs FF/F.
- Latency: a pair first present at edge E is registered at E. The accept strobe is high in the cycle after edge E+STABLE_CYCLES−1.
- State, value, dir, frame_valid and err update at edge E+STABLE_CYCLES. Pulses are exactly one cycle wide.
- Minimum accepted digit dwell is STABLE_CYCLES cycles; a shorter hold is filtered with no effect.
- Reset asserted mid-frame discards the partial frame. After release, the first frame_valid requires a fresh pos3 accept.

## Test plan
- Reset mid-frame: drive pos3 and pos2, then pulse rst_n low for 1 cycle, then present pos1/pos0. Required: all outputs at reset values and no frame_valid. A following full frame for value 7 up gives value=7, dir=1.
- Clean frame (STABLE_CYCLES=4, 8 cycles per digit): 0111/10011111, 1011/00001101, 1101/00111011, 1110/00111011. Required: one frame_valid 4 cycles after pos0 appears, value=13, dir=1, err never asserted.
- Glitch and blanking: insert a 3-cycle pos1 down-arrow pair and 1111 blanking gaps between digits of a valid frame for value 2 down. Required: the glitch is ignored, value=2, dir=0, one frame_valid.
- Sequence error: pos3, then pos1. Required: err pulse, err_code=10, no frame_valid. The next full frame for value 4 is accepted.
- Illegal pattern: pos2 seg=11111111 after a valid pos3. Required: err with code 01 and value unchanged.
- Range and arrow errors:
  - Tens 1, units 7 → err, code 11.
  - Frame with pos1 up and pos0 down → err, code 11.
  - value and dir hold their prior values in both cases.

Source files
------------

// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan decoder: filters the multiplexed digit strobes, decodes each
// digit back to its value and publishes one checked {value, dir} per 4-digit scan.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic [3:0] an_in,
    output logic [3:0] value,
    output logic       dir,
    output logic       frame_valid,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;
    localparam logic [1:0] ERR_CHECK   = 2'b11;

    typedef enum logic [1:0] {WAIT3, HAVE3, HAVE2, HAVE1} state_t;

    // ---------------------------------------------------------------- input / filter
    logic [7:0] seg_q;
    logic [3:0] an_q;
    logic [7:0] cnt, cnt_nxt;
    logic       same;
    logic       acc;

    assign same    = ({an_in, seg_in} == {an_q, seg_q});
    assign cnt_nxt = !same ? 8'd1 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);

    // acc fires only on the edge where the run length first reaches STABLE, so a
    // saturated counter (STABLE=255) cannot re-accept the same pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            an_q  <= 4'hF;
            cnt   <= 8'd0;
            acc   <= 1'b0;
        end else begin
            seg_q <= seg_in;
            an_q  <= an_in;
            cnt   <= cnt_nxt;
            acc   <= (cnt_nxt == STABLE) && (cnt != STABLE);
        end
    end

    // ---------------------------------------------------------------- digit decode
    logic       is_digit;
    logic [1:0] pos;
    logic       legal;
    logic [3:0] dval;

    always_comb begin
        is_digit = 1'b1;
        pos      = 2'd0;
        case (an_q)
            4'b0111: pos = 2'd3;
            4'b1011: pos = 2'd2;
            4'b1101: pos = 2'd1;
            4'b1110: pos = 2'd0;
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        dval  = 4'd0;
        case (pos)
            2'd3: begin
                case (seg_q)
                    8'b0000_0011: dval = 4'd0;
                    8'b1001_1111: dval = 4'd1;
                    default:      legal = 1'b0;
                endcase
            end
            2'd2: begin
                case (seg_q)
                    8'b0000_0011: dval = 4'd0;
                    8'b1001_1111: dval = 4'd1;
                    8'b0010_0101: dval = 4'd2;
                    8'b0000_1101: dval = 4'd3;
                    8'b1001_1001: dval = 4'd4;
                    8'b0100_1001: dval = 4'd5;
                    8'b0100_0001: dval = 4'd6;
                    8'b0001_1111: dval = 4'd7;
                    8'b0000_0001: dval = 4'd8;
                    8'b0000_1001: dval = 4'd9;
                    default:      legal = 1'b0;
                endcase
            end
            default: begin
                case (seg_q)
                    8'b0011_1011: dval = 4'd1;
                    8'b1100_0111: dval = 4'd0;
                    default:      legal = 1'b0;
                endcase
            end
        endcase
    end

    // ---------------------------------------------------------------- frame FSM
    state_t     state, state_n;
    logic       tens_q, tens_n;
    logic [3:0] units_q, units_n;
    logic       arrow_q, arrow_n;
    logic [3:0] value_n;
    logic       dir_n, fv_n, err_n;
    logic [1:0] code_n;
    logic [1:0] exp_pos;
    logic [4:0] res;
    logic       take;

    assign take = acc && is_digit;
    assign res  = (tens_q ? 5'd10 : 5'd0) + {1'b0, units_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT3;
            tens_q      <= 1'b0;
            units_q     <= 4'd0;
            arrow_q     <= 1'b0;
            value       <= 4'd0;
            dir         <= 1'b1;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            state       <= state_n;
            tens_q      <= tens_n;
            units_q     <= units_n;
            arrow_q     <= arrow_n;
            value       <= value_n;
            dir         <= dir_n;
            frame_valid <= fv_n;
            err         <= err_n;
            err_code    <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        tens_n  = tens_q;
        units_n = units_q;
        arrow_n = arrow_q;
        value_n = value;
        dir_n   = dir;
        fv_n    = 1'b0;
        err_n   = 1'b0;
        code_n  = err_code;
        case (state)
            HAVE3:   exp_pos = 2'd2;
            HAVE2:   exp_pos = 2'd1;
            HAVE1:   exp_pos = 2'd0;
            default: exp_pos = 2'd3;
        endcase

        if (take) begin
            if (state == WAIT3) begin
                // only a tens digit can start a frame; other positions resync silently
                if (pos == 2'd3) begin
                    if (legal) begin
                        state_n = HAVE3;
                        tens_n  = dval[0];
                    end else begin
                        err_n  = 1'b1;
                        code_n = ERR_ILLEGAL;
                    end
                end
            end else if (!legal) begin
                // an unreadable digit outranks a sequence error
                err_n   = 1'b1;
                code_n  = ERR_ILLEGAL;
                state_n = WAIT3;
            end else if (pos != exp_pos) begin
                err_n  = 1'b1;
                code_n = ERR_SEQ;
                if (pos == 2'd3) begin
                    state_n = HAVE3;
                    tens_n  = dval[0];
                end else begin
                    state_n = WAIT3;
                end
            end else begin
                case (state)
                    HAVE3: begin
                        units_n = dval;
                        state_n = HAVE2;
                    end
                    HAVE2: begin
                        arrow_n = dval[0];
                        state_n = HAVE1;
                    end
                    default: begin
                        state_n = WAIT3;
                        if (res > 5'd15 || arrow_q != dval[0]) begin
                            err_n  = 1'b1;
                            code_n = ERR_CHECK;
                        end else begin
                            value_n = res[3:0];
                            dir_n   = dval[0];
                            fv_n    = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed and random scans checked against a
// transaction-level model of digit acceptance and frame assembly.
module tb_ssd_scan_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg_in = 8'hFF;
    logic [3:0] an_in = 4'hF;
    logic [3:0] value;
    logic       dir, frame_valid, err;
    logic [1:0] err_code;

    ssd_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .value(value), .dir(dir), .frame_valid(frame_valid),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int kind; int v; int d; int code; } ev_t;  // kind 1=frame, 2=err
    ev_t dut_q[$], exp_q[$];
    ev_t mon_e;

    always @(negedge clk) begin
        if (rst_n && (frame_valid || err)) begin
            chk("excl", {31'd0, frame_valid & err}, 0);
            mon_e.cyc  = cyc;
            mon_e.kind = frame_valid ? 1 : 2;
            mon_e.v    = value;
            mon_e.d    = dir;
            mon_e.code = err_code;
            dut_q.push_back(mon_e);
        end
    end

    // ---------------------------------------------------------------- reference model
    localparam logic [7:0] T0 = 8'h03, T1 = 8'h9F, UP = 8'h3B, DN = 8'hC7;
    logic [7:0] units_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                   8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    int need = 3;          // next position wanted; 3 = waiting for a tens digit
    int m_tens, m_units, m_arrow;
    int m_val = 0, m_dir = 1, m_code = 0;
    logic [11:0] cur_pair = 12'hFFF;
    int run_start = 0;

    function automatic int an2pos(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic int decode(input int p, input logic [7:0] s);
        if (p == 3) return (s == T0) ? 0 : (s == T1) ? 1 : -1;
        if (p == 2) begin
            for (int i = 0; i < 10; i++) if (units_tab[i] == s) return i;
            return -1;
        end
        return (s == UP) ? 1 : (s == DN) ? 0 : -1;
    endfunction

    task automatic push_err(input int c, input int code);
        ev_t e;
        e.cyc = c; e.kind = 2; e.v = m_val; e.d = m_dir; e.code = code;
        m_code = code;
        exp_q.push_back(e);
    endtask

    task automatic model_digit(input int p, input logic [7:0] s, input int c);
        int v;
        ev_t e;
        v = decode(p, s);
        if (need == 3) begin
            if (p == 3) begin
                if (v < 0) push_err(c, 1);
                else begin m_tens = v; need = 2; end
            end
        end else if (v < 0) begin
            push_err(c, 1); need = 3;
        end else if (p != need) begin
            push_err(c, 2);
            if (p == 3) begin m_tens = v; need = 2; end
            else need = 3;
        end else if (p == 2) begin
            m_units = v; need = 1;
        end else if (p == 1) begin
            m_arrow = v; need = 0;
        end else begin
            need = 3;
            if (m_tens * 10 + m_units > 15 || m_arrow != v) push_err(c, 3);
            else begin
                m_val = m_tens * 10 + m_units;
                m_dir = v;
                e.cyc = c; e.kind = 1; e.v = m_val; e.d = m_dir; e.code = m_code;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic close_run();
        int p;
        p = an2pos(cur_pair[11:8]);
        if (cyc - run_start >= S && p >= 0) model_digit(p, cur_pair[7:0], run_start + 1 + S);
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int len);
        if ({a, s} != cur_pair) begin
            close_run();
            cur_pair  = {a, s};
            run_start = cyc;
        end
        an_in  = a;
        seg_in = s;
        repeat (len) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] t, input logic [7:0] u,
                         input logic [7:0] a1, input logic [7:0] a0);
        drive(4'b0111, t, 8);
        drive(4'b1011, u, 8);
        drive(4'b1101, a1, 8);
        drive(4'b1110, a0, 8);
    endtask

    task automatic flush(input string ph);
        int n;
        drive(4'hF, 8'hFF, S + 3);
        chk($sformatf("%s.nev", ph), dut_q.size(), exp_q.size());
        n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.ev%0d.cyc", ph, i), dut_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s.ev%0d.kind", ph, i), dut_q[i].kind, exp_q[i].kind);
            if (exp_q[i].kind == 1) begin
                chk($sformatf("%s.ev%0d.val", ph, i), dut_q[i].v, exp_q[i].v);
                chk($sformatf("%s.ev%0d.dir", ph, i), dut_q[i].d, exp_q[i].d);
            end else begin
                chk($sformatf("%s.ev%0d.code", ph, i), dut_q[i].code, exp_q[i].code);
            end
        end
        dut_q.delete();
        exp_q.delete();
        chk($sformatf("%s.value", ph), value, m_val);
        chk($sformatf("%s.dir", ph), dir, m_dir);
        chk($sformatf("%s.err_code", ph), err_code, m_code);
    endtask

    task automatic do_reset(input string ph);
        drive(4'hF, 8'hFF, 2);
        rst_n = 1'b0;
        #1;
        chk({ph, ".rst_value"}, value, 0);
        chk({ph, ".rst_dir"}, dir, 1);
        chk({ph, ".rst_fv"}, frame_valid, 0);
        chk({ph, ".rst_err"}, err, 0);
        chk({ph, ".rst_code"}, err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        need = 3; m_val = 0; m_dir = 1; m_code = 0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        repeat (3) @(negedge clk);
        chk("por.value", value, 0);
        chk("por.dir", dir, 1);
        chk("por.err_code", err_code, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-frame, then trailing arrows must not complete anything
        drive(4'b0111, T0, 8);
        drive(4'b1011, units_tab[5], 8);
        do_reset("rst1");
        drive(4'b1101, UP, 8);
        drive(4'b1110, UP, 8);
        flush("rst1_tail");
        frame(T0, units_tab[7], UP, UP);
        flush("rst1_frame7");

        frame(T1, units_tab[3], UP, UP);
        flush("clean13");

        // glitches and blanking around a value-2 down frame
        drive(4'b0111, T0, 8);
        drive(4'hF, 8'hFF, 3);
        drive(4'b1011, units_tab[2], 8);
        drive(4'hF, 8'hFF, 2);
        drive(4'b1101, DN, S - 1);
        drive(4'hF, 8'hFF, 2);
        drive(4'b1101, DN, 8);
        drive(4'hF, 8'hFF, 1);
        drive(4'b1110, DN, 8);
        flush("glitch2");

        drive(4'b0111, T0, 8);
        drive(4'b1101, UP, 8);
        flush("seqerr");
        frame(T0, units_tab[4], UP, UP);
        flush("frame4");

        drive(4'b0111, T0, 8);
        drive(4'b1011, 8'hFF, 8);
        flush("illegal");

        frame(T1, units_tab[7], DN, DN);
        flush("range17");
        frame(T0, units_tab[9], UP, DN);
        flush("arrowmis");

        // long hold past counter saturation must accept exactly once
        drive(4'b0111, T1, 300);
        drive(4'b1011, units_tab[5], 8);
        drive(4'b1101, DN, 8);
        drive(4'b1110, DN, 8);
        flush("sat15");

        for (int it = 0; it < 40; it++) begin
            logic [7:0] segs [4];
            logic [3:0] ans [4];
            int skip, bad;
            int t, u, a1, a0;
            t  = $urandom_range(1, 0);
            u  = $urandom_range(9, 0);
            a1 = $urandom_range(1, 0);
            a0 = ($urandom_range(3, 0) == 0) ? 1 - a1 : a1;
            segs[0] = t ? T1 : T0;         ans[0] = 4'b0111;
            segs[1] = units_tab[u];        ans[1] = 4'b1011;
            segs[2] = a1 ? UP : DN;        ans[2] = 4'b1101;
            segs[3] = a0 ? UP : DN;        ans[3] = 4'b1110;
            skip = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 0) : -1;
            bad  = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 0) : -1;
            if (bad >= 0) segs[bad] = 8'($urandom);
            for (int d = 0; d < 4; d++) begin
                if (d != skip) begin
                    if ($urandom_range(5, 0) == 0)
                        drive(ans[$urandom_range(3, 0)], segs[$urandom_range(3, 0)],
                              $urandom_range(S - 1, 1));
                    if ($urandom_range(1, 0) == 1) drive(4'hF, 8'hFF, $urandom_range(3, 1));
                    drive(ans[d], segs[d], S + $urandom_range(5, 0));
                end
            end
            if ($urandom_range(3, 0) == 0) flush($sformatf("rnd%0d", it));
        end
        flush("rnd_end");

        // reset after errors and frames: held outputs return to reset values
        drive(4'b0111, T1, 8);
        do_reset("rst2");
        frame(T0, units_tab[1], DN, DN);
        flush("rst2_frame1");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
